// File: rtl/wave_cmd_parser_if.sv
// ---------------------------------------------------------------------------
// wave_cmd_parser_if
//
// Bundles the signals between the command parser and its neighbours:
//   rx_data / rx_valid    byte stream from the UART receiver
//   wave_type / cmd_rdy / en
//                         control outputs towards the waveform generator
//   tx_data / tx_valid / tx_ready
//                         acknowledge byte towards the UART transmitter
//   err_cnt               saturating count of rejected frames
//
// Modports:
//   master : environment side (drives the receive stream and tx_ready)
//   slave  : parser side (drives generator controls, response, err_cnt)
// ---------------------------------------------------------------------------
interface wave_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] wave_type;
    logic       cmd_rdy;
    logic       en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] err_cnt;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  wave_type, cmd_rdy, en, tx_data, tx_valid, err_cnt
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output wave_type, cmd_rdy, en, tx_data, tx_valid, err_cnt
    );
endinterface

// File: rtl/wave_cmd_parser.sv
// ---------------------------------------------------------------------------
// wave_cmd_parser
//
// Decodes ASCII command frames from the UART byte stream and drives the
// waveform generator controls:
//   *W<d>CR   select waveform d ('1'..'3')
//   *ECR      enable generator (re-issues cmd_rdy with the current type)
//   *DCR      disable generator
// Each completed or rejected frame returns 'K' or '?' through a
// valid/ready handshake. A '*' inside a frame restarts it silently.
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   wave_cmd_parser_if.slave (receive stream, generator controls,
//         response handshake, error counter)
//
// Parameter:
//   TIMEOUT_CYCLES  byte slots allowed without a byte inside a frame
//
// Received bytes pass through one register stage before the FSM, so a byte
// strobed at edge N is acted on at edge N+1 and its effect on the outputs is
// visible after edge N+1. The inter-byte timeout is measured in the same
// registered domain: an expiry occupies the slot a byte would have used, and
// a byte landing in that slot takes priority.
// ---------------------------------------------------------------------------
module wave_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    wave_cmd_parser_if.slave bus
);
    // Timer never needs to hold more than TIMEOUT_CYCLES-1.
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [7:0] CH_STAR = 8'h2A;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_W    = 8'h57;
    localparam logic [7:0] CH_E    = 8'h45;
    localparam logic [7:0] CH_D    = 8'h44;
    localparam logic [7:0] CH_K    = 8'h4B;
    localparam logic [7:0] CH_Q    = 8'h3F;

    typedef enum logic [2:0] {IDLE, CMD, ARG, TERM, RESP} state_t;
    typedef enum logic [1:0] {OP_W, OP_E, OP_D} op_t;

    state_t        state, state_nx;
    op_t           op_q, op_nx;
    logic [1:0]    arg_q, arg_nx;

    logic [7:0]    byte_q;
    logic          byte_vld;
    logic [TW-1:0] timer;
    logic          active;
    logic          timed_out;
    logic          do_exec;
    logic          do_err;

    logic [7:0]    wave_type_q;
    logic          cmd_rdy_q;
    logic          en_q;
    logic [7:0]    tx_data_q;
    logic          tx_valid_q;
    logic [7:0]    err_cnt_q;

    // -----------------------------------------------------------------------
    // Input register. Bytes captured while a response is pending are
    // discarded here; a byte captured on the edge that enters RESP is
    // discarded by the FSM instead.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_vld <= 1'b0;
        end else begin
            // NOTE: clocked state always uses non-blocking assignments so every
            // register samples the pre-edge values regardless of block order.
            byte_vld <= bus.rx_valid && (state != RESP);
        end
    end

    // NOTE: the data byte carries no reset; it is only ever consumed when
    // byte_vld, which is reset, qualifies it.
    always_ff @(posedge clk) begin
        byte_q <= bus.rx_data;
    end

    // -----------------------------------------------------------------------
    // Inter-byte timer. Runs only inside a frame; every frame starts with a
    // '*' byte, so the clear-on-byte also covers entry to CMD.
    // -----------------------------------------------------------------------
    assign active    = (state == CMD) || (state == ARG) || (state == TERM);
    assign timed_out = active && !byte_vld && (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (byte_vld || !active || timed_out) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // FSM state register (with the pending operation and argument)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= OP_W;
            arg_q <= 2'd0;
        end else begin
            state <= state_nx;
            op_q  <= op_nx;
            arg_q <= arg_nx;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and strobes
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nx = state;
        op_nx    = op_q;
        arg_nx   = arg_q;
        do_exec  = 1'b0;
        do_err   = 1'b0;

        case (state)
            IDLE: begin
                if (byte_vld && byte_q == CH_STAR) state_nx = CMD;
            end
            CMD: begin
                if (byte_vld) begin
                    if (byte_q == CH_W) begin
                        op_nx    = OP_W;
                        state_nx = ARG;
                    end else if (byte_q == CH_E) begin
                        op_nx    = OP_E;
                        state_nx = TERM;
                    end else if (byte_q == CH_D) begin
                        op_nx    = OP_D;
                        state_nx = TERM;
                    end else if (byte_q != CH_STAR) begin
                        do_err = 1'b1;
                    end
                end else if (timed_out) begin
                    do_err = 1'b1;
                end
            end
            ARG: begin
                if (byte_vld) begin
                    if (byte_q inside {8'h31, 8'h32, 8'h33}) begin
                        arg_nx   = byte_q[1:0];
                        state_nx = TERM;
                    end else if (byte_q == CH_STAR) begin
                        state_nx = CMD;
                    end else begin
                        do_err = 1'b1;
                    end
                end else if (timed_out) begin
                    do_err = 1'b1;
                end
            end
            TERM: begin
                if (byte_vld) begin
                    if (byte_q == CH_CR) begin
                        do_exec  = 1'b1;
                        state_nx = RESP;
                    end else if (byte_q == CH_STAR) begin
                        state_nx = CMD;
                    end else begin
                        do_err = 1'b1;
                    end
                end else if (timed_out) begin
                    do_err = 1'b1;
                end
            end
            RESP: begin
                if (bus.tx_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (do_err) state_nx = RESP;
    end

    // -----------------------------------------------------------------------
    // Generator controls, response and error counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wave_type_q <= 8'h00;
            cmd_rdy_q   <= 1'b0;
            en_q        <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            cmd_rdy_q <= 1'b0;
            if (do_exec) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= CH_K;
                case (op_q)
                    OP_W: begin
                        wave_type_q <= {6'b0, arg_q};
                        cmd_rdy_q   <= 1'b1;
                    end
                    OP_E: begin
                        // Re-issue the current type: the generator ignores
                        // cmd_rdy while disabled.
                        en_q      <= 1'b1;
                        cmd_rdy_q <= 1'b1;
                    end
                    OP_D:    en_q <= 1'b0;
                    default: ;
                endcase
            end else if (do_err) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= CH_Q;
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end else if (state == RESP && bus.tx_ready) begin
                tx_valid_q <= 1'b0;
            end
        end
    end

    assign bus.wave_type = wave_type_q;
    assign bus.cmd_rdy   = cmd_rdy_q;
    assign bus.en        = en_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_wave_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_wave_cmd_parser
//
// Directed scenarios followed by randomized frames. Expected responses come
// from a frame classifier that works on whole byte sequences: the bytes after
// the last '*' either spell a complete command or the frame is rejected.
// ---------------------------------------------------------------------------
module tb_wave_cmd_parser;
    localparam logic [7:0] CH_STAR = 8'h2A;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_W    = 8'h57;
    localparam logic [7:0] CH_E    = 8'h45;
    localparam logic [7:0] CH_D    = 8'h44;
    localparam logic [7:0] CH_K    = 8'h4B;
    localparam logic [7:0] CH_Q    = 8'h3F;

    typedef enum int {R_W, R_E, R_D, R_ERR} result_e;

    logic clk;
    logic rst;
    wave_cmd_parser_if bus ();

    wave_cmd_parser #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [7:0] m_wave;
    logic       m_en;
    int         m_err;

    // Output monitor: cmd_rdy pulses and wave_type stability
    int         rdy_count = 0;
    int         wave_bad  = 0;
    int         rdy_long  = 0;
    logic [7:0] prev_wave = 8'h00;
    logic       prev_rdy  = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cmd_rdy) rdy_count <= rdy_count + 1;
            if (bus.wave_type !== prev_wave && !bus.cmd_rdy) wave_bad <= wave_bad + 1;
            if (bus.cmd_rdy && prev_rdy) rdy_long <= rdy_long + 1;
        end
        prev_wave <= bus.wave_type;
        prev_rdy  <= bus.cmd_rdy;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fr[$]);
        foreach (fr[i]) send_byte(fr[i]);
    endtask

    // Whole-frame classifier: only the bytes after the last '*' matter.
    function automatic result_e classify(input logic [7:0] fr[$], output logic [1:0] d);
        logic [7:0] body[$];
        logic [7:0] a;
        int last;
        last = -1;
        d    = 2'd0;
        foreach (fr[i]) if (fr[i] == CH_STAR) last = i;
        for (int i = last + 1; i < fr.size(); i++) body.push_back(fr[i]);
        if (body.size() == 3 && body[0] == CH_W && body[2] == CH_CR) begin
            a = body[1];
            if (a >= 8'h31 && a <= 8'h33) begin
                d = a[1:0];
                return R_W;
            end
        end
        if (body.size() == 2 && body[0] == CH_E && body[1] == CH_CR) return R_E;
        if (body.size() == 2 && body[0] == CH_D && body[1] == CH_CR) return R_D;
        return R_ERR;
    endfunction

    // Called right after the last byte of a frame (or the last idle slot of a
    // timeout) was sampled. Checks the response one edge later, optionally
    // stalls the transmitter for 'hold' cycles, then completes the handshake.
    task automatic finish_frame(input result_e r, input logic [1:0] d, input int hold, input bit junk);
        logic [7:0] exp_char;
        logic       exp_rdy;
        exp_char = CH_K;
        exp_rdy  = 1'b0;
        case (r)
            R_W: begin
                m_wave  = {6'b0, d};
                exp_rdy = 1'b1;
            end
            R_E: begin
                m_en    = 1'b1;
                exp_rdy = 1'b1;
            end
            R_D: m_en = 1'b0;
            default: begin
                exp_char = CH_Q;
                if (m_err < 255) m_err = m_err + 1;
            end
        endcase

        bus.tx_ready = (hold == 0);
        @(posedge clk);
        #1;
        check("resp_valid", bus.tx_valid, 1);
        check("resp_data", bus.tx_data, exp_char);
        check("resp_cmd_rdy", bus.cmd_rdy, exp_rdy);
        check("resp_wave", bus.wave_type, m_wave);
        check("resp_en", bus.en, m_en);
        check("resp_err_cnt", bus.err_cnt, m_err);

        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                bus.rx_data  = 8'h78;
                bus.rx_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            check("hold_valid", bus.tx_valid, 1);
            check("hold_data", bus.tx_data, exp_char);
            check("hold_cmd_rdy", bus.cmd_rdy, 0);
        end

        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("resp_done", bus.tx_valid, 0);
        check("after_err_cnt", bus.err_cnt, m_err);
    endtask

    task automatic run_frame(input logic [7:0] fr[$], input int hold, input bit junk);
        result_e    r;
        logic [1:0] d;
        r = classify(fr, d);
        send_frame(fr);
        finish_frame(r, d, hold, junk);
    endtask

    function automatic logic [7:0] rand_byte_not(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] e);
        logic [7:0] x;
        do x = 8'($urandom); while (x == a || x == b || x == c || x == e);
        return x;
    endfunction

    initial begin
        int         rdy_base;
        int         seen;
        logic [7:0] fr[$];

        m_wave = 8'h00;
        m_en   = 1'b0;
        m_err  = 0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        rst = 1'b1;

        // Reset values
        #2;
        check("rst_wave", bus.wave_type, 8'h00);
        check("rst_cmd_rdy", bus.cmd_rdy, 0);
        check("rst_en", bus.en, 0);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_err_cnt", bus.err_cnt, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // *W2CR then *ECR
        rdy_base = rdy_count;
        run_frame('{CH_STAR, CH_W, 8'h32, CH_CR}, 0, 1'b0);
        run_frame('{CH_STAR, CH_E, CH_CR}, 0, 1'b0);
        check("w2_e_rdy_pulses", rdy_count - rdy_base, 2);

        // *W7 rejected at '7'; trailing CR lands in IDLE and is ignored
        rdy_base = rdy_count;
        run_frame('{CH_STAR, CH_W, 8'h37}, 0, 1'b0);
        send_byte(CH_CR);
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.tx_valid) seen++;
        end
        check("cr_in_idle_resp", seen, 0);
        check("cr_in_idle_err", bus.err_cnt, m_err);
        check("w7_no_rdy", rdy_count - rdy_base, 0);

        // Resync *W*W3CR, then *DCR
        rdy_base = rdy_count;
        run_frame('{CH_STAR, CH_W, CH_STAR, CH_W, 8'h33, CH_CR}, 0, 1'b0);
        check("resync_rdy_pulses", rdy_count - rdy_base, 1);
        rdy_base = rdy_count;
        run_frame('{CH_STAR, CH_D, CH_CR}, 0, 1'b0);
        check("disable_no_rdy", rdy_count - rdy_base, 0);

        // *W1 then silence: '?' after 16 empty slots
        send_frame('{CH_STAR, CH_W, 8'h31});
        seen = 0;
        repeat (16) begin
            @(posedge clk);
            #1;
            if (bus.tx_valid) seen++;
        end
        check("timeout_early_resp", seen, 0);
        bus.tx_ready = 1'b1;
        finish_frame(R_ERR, 2'd0, 0, 1'b0);
        // Back in IDLE: a normal frame works straight away
        run_frame('{CH_STAR, CH_W, 8'h31, CH_CR}, 0, 1'b0);

        // Backpressure: 20 stalled cycles with 'x' bytes arriving
        run_frame('{CH_STAR, CH_E, CH_CR}, 20, 1'b1);

        // Randomized frames
        for (int n = 0; n < 40; n++) begin
            int kind;
            fr = {};
            if ($urandom_range(0, 3) == 0) fr.push_back(rand_byte_not(CH_STAR, CH_STAR, CH_STAR, CH_STAR));
            if ($urandom_range(0, 3) == 0) begin
                fr.push_back(CH_STAR);
                if ($urandom_range(0, 1) == 0) fr.push_back(CH_W);
            end
            fr.push_back(CH_STAR);
            kind = $urandom_range(0, 5);
            case (kind)
                0: begin
                    fr.push_back(CH_W);
                    fr.push_back(8'h31 + 8'($urandom_range(0, 2)));
                    fr.push_back(CH_CR);
                end
                1: begin
                    fr.push_back(CH_E);
                    fr.push_back(CH_CR);
                end
                2: begin
                    fr.push_back(CH_D);
                    fr.push_back(CH_CR);
                end
                3: fr.push_back(rand_byte_not(CH_STAR, CH_W, CH_E, CH_D));
                4: begin
                    fr.push_back(CH_W);
                    fr.push_back(rand_byte_not(CH_STAR, 8'h31, 8'h32, 8'h33));
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        fr.push_back(CH_W);
                        fr.push_back(8'h33);
                    end else begin
                        fr.push_back(CH_D);
                    end
                    fr.push_back(rand_byte_not(CH_STAR, CH_CR, CH_CR, CH_CR));
                end
            endcase
            run_frame(fr, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0, 1'b0);
        end

        // 300 rejected frames: counter saturates
        for (int n = 0; n < 300; n++) run_frame('{CH_STAR, 8'h5A}, 0, 1'b0);
        check("err_saturated", bus.err_cnt, 8'hFF);

        // Non-reset controls before the mid-frame reset
        run_frame('{CH_STAR, CH_W, 8'h33, CH_CR}, 0, 1'b0);
        run_frame('{CH_STAR, CH_E, CH_CR}, 0, 1'b0);

        // Reset in the middle of *W2
        send_byte(CH_STAR);
        send_byte(CH_W);
        bus.rx_data  = 8'h32;
        bus.rx_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_wave", bus.wave_type, 8'h00);
        check("midrst_cmd_rdy", bus.cmd_rdy, 0);
        check("midrst_en", bus.en, 0);
        check("midrst_tx_valid", bus.tx_valid, 0);
        check("midrst_tx_data", bus.tx_data, 8'h00);
        check("midrst_err_cnt", bus.err_cnt, 8'h00);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_wave = 8'h00;
        m_en   = 1'b0;
        m_err  = 0;
        seen   = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.tx_valid) seen++;
        end
        check("midrst_no_resp", seen, 0);
        check("midrst_err_after", bus.err_cnt, 8'h00);
        run_frame('{CH_STAR, CH_W, 8'h32, CH_CR}, 0, 1'b0);

        check("wave_changed_without_rdy", wave_bad, 0);
        check("cmd_rdy_longer_than_one", rdy_long, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
